xbar_slave_mem: RTL and testbench

- Parametrised, synthesizable slave-side responder for the cross-bar req/ack slave port.
- Successor to the behavioural slave VIP. Adds:
  - word-addressed backing memory of configurable depth;
  - fixed or pseudo-random wait states;
  - out-of-window error response;
  - saturating access statistics.
- Sits on one cross_bar_top slave port, in the bench or on FPGA bring-up, as the target of master traffic.

---
 rtl/xbar_slave_mem.sv | 135 +++++++++++++
 tb/tb_xbar_slave_mem.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_slave_mem.sv
// Slave-side responder for one cross-bar req/ack port: word-addressed backing memory,
// fixed or LFSR-driven wait states, out-of-window error response and saturating counters.
module xbar_slave_mem #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                SLAVE_W   = 2,
    parameter int                MEM_AW    = 8,
    parameter int                LAT_MODE  = 0,
    parameter int                LAT_W     = 3,
    parameter int                LATENCY   = 2,
    parameter logic [7:0]        LFSR_SEED = 8'hA5,
    parameter logic [DATA_W-1:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              slave_req,
    input  logic [ADDR_W-1:0] slave_addr,
    input  logic              slave_cmd,
    input  logic [DATA_W-1:0] slave_wdata,
    output logic              slave_ack,
    output logic [DATA_W-1:0] slave_rdata,
    output logic              busy,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       err_cnt
);

    localparam int               DEPTH     = 2 ** MEM_AW;
    localparam int               WIN_HI    = ADDR_W - SLAVE_W - 1;
    localparam int               WIN_LO    = MEM_AW + 2;
    localparam logic [LAT_W-1:0] LAT_FIXED = LAT_W'(LATENCY);
    localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} state_t;

    state_t            state, state_next;
    logic [LAT_W-1:0]  cnt, cnt_next, lat_load;
    logic [7:0]        lfsr;
    logic              lfsr_fb;
    logic              accept;
    logic [WIN_HI:2]   addr_q;
    logic              cmd_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MEM_AW-1:0] index;
    logic              in_window;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              unused_addr_bits;

    // Slave-select bits and the byte offset play no part in the decode.
    assign unused_addr_bits = ^{slave_addr[ADDR_W-1:WIN_HI+1], slave_addr[1:0]};

    assign index     = addr_q[MEM_AW+1:2];
    assign in_window = (addr_q[WIN_HI:WIN_LO] == '0);
    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign lat_load  = (LAT_MODE == 0) ? LAT_FIXED : lfsr[LAT_W-1:0];
    assign busy      = (state != ST_IDLE);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (slave_req) begin
                    accept     = 1'b1;
                    cnt_next   = lat_load;
                    state_next = (lat_load == '0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!slave_req) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - LAT_ONE;
                    if (cnt == LAT_ONE) state_next = ST_ACK;
                end
            end
            ST_ACK:  state_next = ST_HOLD;
            ST_HOLD: if (!slave_req) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            lfsr        <= LFSR_SEED;
            slave_ack   <= 1'b0;
            slave_rdata <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            err_cnt     <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            lfsr      <= {lfsr[6:0], lfsr_fb};
            slave_ack <= (state == ST_ACK);
            if (state == ST_ACK) begin
                if (!in_window) begin
                    err_cnt <= sat_inc(err_cnt);
                    if (!cmd_q) slave_rdata <= ERR_DATA;
                end else if (cmd_q) begin
                    wr_cnt <= sat_inc(wr_cnt);
                end else begin
                    rd_cnt      <= sat_inc(rd_cnt);
                    slave_rdata <= mem[index];
                end
            end
        end
    end

    // NOTE: the request capture registers and the memory array carry no reset; only
    // control state must be defined out of reset, and memory contents must survive it.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= slave_addr[WIN_HI:2];
            cmd_q   <= slave_cmd;
            wdata_q <= slave_wdata;
        end
    end

    // The aresetn term keeps a reset that lands on the ACK edge from committing the write.
    always_ff @(posedge clk) begin
        if (aresetn && state == ST_ACK && cmd_q && in_window) begin
            mem[index] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_xbar_slave_mem.sv
// Self-checking bench for xbar_slave_mem: three instances (fixed L=2, fixed L=5, LFSR latency)
// driven by directed and randomized accesses and compared with a behavioural model.
module tb_xbar_slave_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn;
    logic        req     [3];
    logic [31:0] addr    [3];
    logic        cmd     [3];
    logic [31:0] wdata   [3];
    logic        ack     [3];
    logic [31:0] rdata   [3];
    logic        busy    [3];
    logic [15:0] wr_cnt  [3];
    logic [15:0] rd_cnt  [3];
    logic [15:0] err_cnt [3];

    // Instance 0: fixed latency 2; instance 1: fixed latency 5; instance 2: LFSR latency.
    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            xbar_slave_mem #(
                .LAT_MODE (g == 2 ? 1 : 0),
                .LATENCY  (g == 1 ? 5 : 2)
            ) u_dut (
                .clk         (clk),
                .aresetn     (aresetn),
                .slave_req   (req[g]),
                .slave_addr  (addr[g]),
                .slave_cmd   (cmd[g]),
                .slave_wdata (wdata[g]),
                .slave_ack   (ack[g]),
                .slave_rdata (rdata[g]),
                .busy        (busy[g]),
                .wr_cnt      (wr_cnt[g]),
                .rd_cnt      (rd_cnt[g]),
                .err_cnt     (err_cnt[g])
            );
        end
    endgenerate

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [7:0]  m_lfsr;
    logic [31:0] m_mem   [3][256];
    logic [31:0] m_rdata [3];
    int          m_wr    [3];
    int          m_rd    [3];
    int          m_er    [3];

    // Polynomial x^8+x^6+x^5+x^4+1: feedback is the parity of the tapped stages.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    always @(posedge clk) m_lfsr <= !aresetn ? 8'hA5 : lfsr_step(m_lfsr);

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    function automatic logic [31:0] rand_addr(input bit oow);
        logic [31:0] a;
        a       = $urandom;
        a[9:6]  = 4'd0;
        a[29:10] = oow ? 20'($urandom_range(1, 1048575)) : 20'd0;
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int u = 0; u < 3; u++) begin
            m_rdata[u] = '0;
            m_wr[u] = 0;
            m_rd[u] = 0;
            m_er[u] = 0;
        end
    endtask

    // One complete access, entered and left at a negedge with the DUT idle.
    task automatic access(input int u, input logic [31:0] a, input logic c,
                          input logic [31:0] d, input int hold);
        int   exp_wait, waits, extra, not_busy;
        logic got;
        logic [7:0] idx;
        logic inwin;
        exp_wait = (u == 2) ? int'(m_lfsr[2:0]) : ((u == 1) ? 5 : 2);
        addr[u]  = a;
        cmd[u]   = c;
        wdata[u] = d;
        req[u]   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        addr[u]  = $urandom;
        cmd[u]   = ~c;
        wdata[u] = $urandom;
        waits = 0;
        got   = 1'b0;
        while (!got && waits < 40) begin
            @(posedge clk);
            @(negedge clk);
            if (ack[u]) got = 1'b1;
            else waits++;
        end
        idx   = a[9:2];
        inwin = (a[29:10] == 20'd0);
        if (!inwin) begin
            m_er[u] = sat(m_er[u]);
            if (!c) m_rdata[u] = 32'hDEADBEEF;
        end else if (c) begin
            m_mem[u][idx] = d;
            m_wr[u] = sat(m_wr[u]);
        end else begin
            m_rdata[u] = m_mem[u][idx];
            m_rd[u] = sat(m_rd[u]);
        end
        check($sformatf("u%0d_ack_seen", u), 32'(got), 32'd1);
        check($sformatf("u%0d_ack_wait", u), waits, exp_wait);
        check($sformatf("u%0d_rdata", u), rdata[u], m_rdata[u]);
        extra    = 0;
        not_busy = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack[u]) extra++;
            if (!busy[u]) not_busy++;
        end
        if (hold > 0) begin
            check($sformatf("u%0d_hold_extra_ack", u), extra, 0);
            check($sformatf("u%0d_hold_busy_low", u), not_busy, 0);
        end
        req[u] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("u%0d_idle_busy", u), 32'(busy[u]), 32'd0);
        check($sformatf("u%0d_wr_cnt", u), 32'(wr_cnt[u]), m_wr[u]);
        check($sformatf("u%0d_rd_cnt", u), 32'(rd_cnt[u]), m_rd[u]);
        check($sformatf("u%0d_err_cnt", u), 32'(err_cnt[u]), m_er[u]);
    endtask

    initial begin
        int acks;
        aresetn = 1'b0;
        for (int u = 0; u < 3; u++) begin
            req[u]   = 1'b0;
            addr[u]  = '0;
            cmd[u]   = 1'b0;
            wdata[u] = '0;
        end
        reset_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;

        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d_rst_ack", u), 32'(ack[u]), 32'd0);
            check($sformatf("u%0d_rst_rdata", u), rdata[u], 32'd0);
            check($sformatf("u%0d_rst_busy", u), 32'(busy[u]), 32'd0);
            check($sformatf("u%0d_rst_wr", u), 32'(wr_cnt[u]), 32'd0);
            check($sformatf("u%0d_rst_rd", u), 32'(rd_cnt[u]), 32'd0);
            check($sformatf("u%0d_rst_err", u), 32'(err_cnt[u]), 32'd0);
        end

        // Basic write then read-back with fixed latency 2.
        access(0, 32'h0000_0004, 1'b1, 32'h0F0F_0F0F, 0);
        access(0, 32'h0000_0004, 1'b0, 32'h0, 0);
        check("basic_rdata", rdata[0], 32'h0F0F_0F0F);

        // Request held high 10 cycles past the ack.
        access(0, 32'h0000_0010, 1'b1, 32'h1111_2222, 10);
        access(0, 32'h0000_0010, 1'b0, 32'h0, 10);

        // Out-of-window write is dropped, read returns the error word.
        access(0, 32'h0000_0000, 1'b1, 32'hA5A5_0001, 0);
        access(0, 32'h0000_0400, 1'b1, 32'h1234_5678, 0);
        access(0, 32'h0000_0400, 1'b0, 32'h0, 0);
        check("oow_rdata", rdata[0], 32'hDEADBEEF);
        access(0, 32'h0000_0000, 1'b0, 32'h0, 0);
        check("oow_mem0_kept", rdata[0], 32'hA5A5_0001);

        // Randomized traffic on the fixed-latency instance.
        for (int i = 0; i < 16; i++) access(0, 32'(i * 4), 1'b1, $urandom, 0);
        for (int i = 0; i < 24; i++)
            access(0, rand_addr($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), $urandom, 0);

        // Abort during WAIT with latency 5.
        access(1, 32'h0000_0008, 1'b1, 32'hCAFE_0008, 0);
        addr[1]  = 32'h0000_0008;
        cmd[1]   = 1'b1;
        wdata[1] = 32'hBAD0_0008;
        req[1]   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        req[1] = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack[1]) acks++;
        end
        check("abort_no_ack", acks, 0);
        check("abort_idle", 32'(busy[1]), 32'd0);
        check("abort_wr_cnt", 32'(wr_cnt[1]), m_wr[1]);
        check("abort_rdata", rdata[1], m_rdata[1]);
        access(1, 32'h0000_0008, 1'b0, 32'h0, 0);

        // LFSR-driven latency: back-to-back reads against the model sequence.
        for (int i = 0; i < 16; i++) access(2, 32'(i * 4), 1'b1, $urandom, 0);
        for (int i = 0; i < 32; i++) access(2, rand_addr(1'b0), 1'b0, 32'h0, 0);
        for (int i = 0; i < 300 && m_lfsr[2:0] != 3'd0; i++) @(negedge clk);
        access(2, 32'h0000_0004, 1'b0, 32'h0, 0);

        // Reset mid-WAIT with a write pending.
        access(1, 32'h0000_000C, 1'b1, 32'h5EED_000C, 0);
        addr[1]  = 32'h0000_000C;
        cmd[1]   = 1'b1;
        wdata[1] = 32'hBAD0_000C;
        req[1]   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b0;
        req[1]  = 1'b0;
        acks = 0;
        @(posedge clk);
        @(negedge clk);
        if (ack[1]) acks++;
        aresetn = 1'b1;
        reset_model();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack[1]) acks++;
        end
        check("rst_mid_no_ack", acks, 0);
        check("rst_mid_wr", 32'(wr_cnt[1]), 32'd0);
        check("rst_mid_rdata", rdata[1], 32'd0);
        check("rst_mid_busy", 32'(busy[1]), 32'd0);
        check("rst_mid_u0_wr", 32'(wr_cnt[0]), 32'd0);
        access(1, 32'h0000_000C, 1'b0, 32'h0, 0);
        check("rst_mid_mem_kept", rdata[1], 32'h5EED_000C);
        access(2, 32'h0000_0008, 1'b0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
